// File: rtl/dispatch_buffer_pkg.sv
// dispatch_buffer_pkg: instruction type codes, tag constants and target selection for the dispatch stage
package dispatch_buffer_pkg;

    // Instruction type codes; the memory group is the contiguous range TYPE_LB..TYPE_SW
    localparam int TYPE_ADD = 1;
    localparam int TYPE_SUB = 2;
    localparam int TYPE_LB  = 10;
    localparam int TYPE_LH  = 11;
    localparam int TYPE_LW  = 12;
    localparam int TYPE_LBU = 13;
    localparam int TYPE_LHU = 14;
    localparam int TYPE_SB  = 15;
    localparam int TYPE_SH  = 16;
    localparam int TYPE_SW  = 17;

    // ROB tag 0 means "no dependency" and is never allocated
    localparam int ROB_NULL = 0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Back-end unit that receives an issued instruction
    typedef enum logic {
        TGT_RS  = 1'b0,
        TGT_LSQ = 1'b1
    } target_e;

    // Memory operations go to the load/store queue, everything else to the reservation station
    function automatic target_e target_of(input logic [31:0] t);
        return (t >= 32'(TYPE_LB) && t <= 32'(TYPE_SW)) ? TGT_LSQ : TGT_RS;
    endfunction

endpackage

// File: rtl/dispatch_operand_resolve.sv
// dispatch_operand_resolve: picks value/tag for one source operand from x0, rename forwarding, regfile, ROB and CDB
module dispatch_operand_resolve
    import dispatch_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int REG_W = 5,
    parameter int NCDB  = 2
) (
    input  logic [REG_W-1:0]       src_i,
    input  logic                   reg_busy_i,
    input  logic [XLEN-1:0]        reg_data_i,
    input  logic [ROB_W-1:0]       reg_robnum_i,
    input  logic                   rob_rdy_i,
    input  logic [XLEN-1:0]        rob_data_i,
    input  logic [NCDB-1:0]        cdb_valid_i,
    input  logic [NCDB*ROB_W-1:0]  cdb_tag_i,
    input  logic [NCDB*XLEN-1:0]   cdb_data_i,
    input  logic                   fwd_valid_i,
    input  logic [REG_W-1:0]       fwd_rd_i,
    input  logic [ROB_W-1:0]       fwd_tag_i,
    output logic [XLEN-1:0]        v_o,
    output logic [ROB_W-1:0]       q_o
);

    logic            cdb_hit;
    logic [XLEN-1:0] cdb_v;

    // Scan channels from highest to lowest so the lowest matching index is the one kept
    always_comb begin
        cdb_hit = 1'b0;
        cdb_v   = '0;
        for (int n = NCDB - 1; n >= 0; n--) begin
            if (cdb_valid_i[n] && cdb_tag_i[n*ROB_W +: ROB_W] == reg_robnum_i) begin
                cdb_hit = 1'b1;
                cdb_v   = cdb_data_i[n*XLEN +: XLEN];
            end
        end
    end

    // Priority chain; forwarding beats the regfile because the rename table lags one cycle
    always_comb begin
        v_o = '0;
        q_o = reg_robnum_i;
        if (src_i == '0) begin
            q_o = ROB_W'(ROB_NULL);
        end else if (fwd_valid_i && fwd_rd_i == src_i) begin
            q_o = fwd_tag_i;
        end else if (!reg_busy_i) begin
            v_o = reg_data_i;
            q_o = ROB_W'(ROB_NULL);
        end else if (rob_rdy_i) begin
            v_o = rob_data_i;
            q_o = ROB_W'(ROB_NULL);
        end else if (cdb_hit) begin
            v_o = cdb_v;
            q_o = ROB_W'(ROB_NULL);
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: decode FIFO that resolves head operands and issues one instruction per cycle to ROB/RS/LSQ
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int REG_W  = 5,
    parameter int TYPE_W = 6,
    parameter int NCDB   = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  dec_valid_in,
    output logic                  dec_ready_out,
    input  logic [TYPE_W-1:0]     dec_type_in,
    input  logic [REG_W-1:0]      dec_rs1_in,
    input  logic [REG_W-1:0]      dec_rs2_in,
    input  logic [REG_W-1:0]      dec_rd_in,
    input  logic [XLEN-1:0]       dec_imm_in,
    input  logic [XLEN-1:0]       dec_pc_in,
    output logic [REG_W-1:0]      reg_rs1_out,
    output logic [REG_W-1:0]      reg_rs2_out,
    input  logic [XLEN-1:0]       reg_rs1_data_in,
    input  logic                  reg_rs1_busy_in,
    input  logic [ROB_W-1:0]      reg_rs1_robnum_in,
    input  logic [XLEN-1:0]       reg_rs2_data_in,
    input  logic                  reg_rs2_busy_in,
    input  logic [ROB_W-1:0]      reg_rs2_robnum_in,
    output logic [ROB_W-1:0]      rob_rs1_out,
    output logic [ROB_W-1:0]      rob_rs2_out,
    input  logic                  rob_rs1_rdy_in,
    input  logic [XLEN-1:0]       rob_rs1_data_in,
    input  logic                  rob_rs2_rdy_in,
    input  logic [XLEN-1:0]       rob_rs2_data_in,
    input  logic [ROB_W-1:0]      rob_idle_pos_in,
    input  logic                  rob_full_in,
    input  logic                  rs_full_in,
    input  logic                  lsq_full_in,
    input  logic [NCDB-1:0]       cdb_valid_in,
    input  logic [NCDB*ROB_W-1:0] cdb_tag_in,
    input  logic [NCDB*XLEN-1:0]  cdb_data_in,
    output logic                  rs_en_out,
    output logic                  lsq_en_out,
    output logic                  rob_en_out,
    output logic                  reg_en_out,
    output logic [REG_W-1:0]      reg_rd_out,
    output logic [ROB_W-1:0]      reg_rd_robnum_out,
    output logic [ROB_W-1:0]      dest_out,
    output logic [TYPE_W-1:0]     rob_type_out,
    output logic [TYPE_W-1:0]     type_out,
    output logic [REG_W-1:0]      rob_reg_pos_out,
    output logic [XLEN-1:0]       vj_out,
    output logic [XLEN-1:0]       vk_out,
    output logic [ROB_W-1:0]      qj_out,
    output logic [ROB_W-1:0]      qk_out,
    output logic [XLEN-1:0]       A_out,
    output logic [XLEN-1:0]       pc_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TYPE_W-1:0] type_m [DEPTH];
    logic [REG_W-1:0]  rs1_m  [DEPTH];
    logic [REG_W-1:0]  rs2_m  [DEPTH];
    logic [REG_W-1:0]  rd_m   [DEPTH];
    logic [XLEN-1:0]   imm_m  [DEPTH];
    logic [XLEN-1:0]   pc_m   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic              rs_en_q, rs_en_d, lsq_en_q, lsq_en_d;
    logic              rob_en_q, rob_en_d, reg_en_q, reg_en_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [ROB_W-1:0]  dest_q, dest_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [XLEN-1:0]   vj_q, vj_d, vk_q, vk_d, a_q, a_d, pc_q, pc_d;
    logic [ROB_W-1:0]  qj_q, qj_d, qk_q, qk_d;
    logic              fwd_vld_q, fwd_vld_d;
    logic [REG_W-1:0]  fwd_rd_q, fwd_rd_d;
    logic [ROB_W-1:0]  fwd_tag_q, fwd_tag_d;

    logic [TYPE_W-1:0] h_type;
    logic [REG_W-1:0]  h_rd;
    target_e           h_tgt;
    logic              enq, iss;
    logic [XLEN-1:0]   vj_res, vk_res;
    logic [ROB_W-1:0]  qj_res, qk_res;

    assign h_type        = type_m[head_q];
    assign h_rd          = rd_m[head_q];
    assign h_tgt         = target_of(32'(h_type));
    assign reg_rs1_out   = rs1_m[head_q];
    assign reg_rs2_out   = rs2_m[head_q];
    assign rob_rs1_out   = reg_rs1_robnum_in;
    assign rob_rs2_out   = reg_rs2_robnum_in;
    assign dec_ready_out = cnt_q < (PTR_W+1)'(DEPTH);

    assign enq = rdy_in && !flush_in && dec_valid_in && dec_ready_out;
    assign iss = rdy_in && !flush_in && cnt_q != '0 && !rob_full_in
              && (h_tgt == TGT_LSQ ? !lsq_full_in : !rs_full_in);

    dispatch_operand_resolve #(
        .XLEN (XLEN), .ROB_W(ROB_W), .REG_W(REG_W), .NCDB(NCDB)
    ) u_rs1 (
        .src_i       (reg_rs1_out),
        .reg_busy_i  (reg_rs1_busy_in),
        .reg_data_i  (reg_rs1_data_in),
        .reg_robnum_i(reg_rs1_robnum_in),
        .rob_rdy_i   (rob_rs1_rdy_in),
        .rob_data_i  (rob_rs1_data_in),
        .cdb_valid_i (cdb_valid_in),
        .cdb_tag_i   (cdb_tag_in),
        .cdb_data_i  (cdb_data_in),
        .fwd_valid_i (fwd_vld_q),
        .fwd_rd_i    (fwd_rd_q),
        .fwd_tag_i   (fwd_tag_q),
        .v_o         (vj_res),
        .q_o         (qj_res)
    );

    dispatch_operand_resolve #(
        .XLEN (XLEN), .ROB_W(ROB_W), .REG_W(REG_W), .NCDB(NCDB)
    ) u_rs2 (
        .src_i       (reg_rs2_out),
        .reg_busy_i  (reg_rs2_busy_in),
        .reg_data_i  (reg_rs2_data_in),
        .reg_robnum_i(reg_rs2_robnum_in),
        .rob_rdy_i   (rob_rs2_rdy_in),
        .rob_data_i  (rob_rs2_data_in),
        .cdb_valid_i (cdb_valid_in),
        .cdb_tag_i   (cdb_tag_in),
        .cdb_data_i  (cdb_data_in),
        .fwd_valid_i (fwd_vld_q),
        .fwd_rd_i    (fwd_rd_q),
        .fwd_tag_i   (fwd_tag_q),
        .v_o         (vk_res),
        .q_o         (qk_res)
    );

    // FIFO storage is written only on accepted enqueues and needs no reset
    always_ff @(posedge clk_in) begin
        if (enq) begin
            type_m[tail_q] <= dec_type_in;
            rs1_m[tail_q]  <= dec_rs1_in;
            rs2_m[tail_q]  <= dec_rs2_in;
            rd_m[tail_q]   <= dec_rd_in;
            imm_m[tail_q]  <= dec_imm_in;
            pc_m[tail_q]   <= dec_pc_in;
        end
    end

    // Pointer/count update; flush wins over enqueue and issue, a stalled pipeline holds
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (rdy_in && flush_in) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            tail_d = enq ? tail_q + PTR_W'(1) : tail_q;
            head_d = iss ? head_q + PTR_W'(1) : head_q;
            cnt_d  = cnt_q + (PTR_W+1)'(enq) - (PTR_W+1)'(iss);
        end
    end

    // Issue registers and the one-cycle rename forwarding record
    always_comb begin
        rs_en_d   = rs_en_q;
        lsq_en_d  = lsq_en_q;
        rob_en_d  = rob_en_q;
        reg_en_d  = reg_en_q;
        rd_d      = rd_q;
        dest_d    = dest_q;
        type_d    = type_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        a_d       = a_q;
        pc_d      = pc_q;
        fwd_vld_d = fwd_vld_q;
        fwd_rd_d  = fwd_rd_q;
        fwd_tag_d = fwd_tag_q;
        if (rdy_in) begin
            rs_en_d   = iss && h_tgt == TGT_RS;
            lsq_en_d  = iss && h_tgt == TGT_LSQ;
            rob_en_d  = iss;
            reg_en_d  = iss && h_rd != '0;
            fwd_vld_d = iss && h_rd != '0;
            if (iss) begin
                rd_d      = h_rd;
                dest_d    = rob_idle_pos_in;
                type_d    = h_type;
                vj_d      = vj_res;
                vk_d      = vk_res;
                qj_d      = qj_res;
                qk_d      = qk_res;
                a_d       = imm_m[head_q];
                pc_d      = pc_m[head_q];
                fwd_rd_d  = h_rd;
                fwd_tag_d = rob_idle_pos_in;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            rs_en_q   <= DISABLE;
            lsq_en_q  <= DISABLE;
            rob_en_q  <= DISABLE;
            reg_en_q  <= DISABLE;
            rd_q      <= '0;
            dest_q    <= '0;
            type_q    <= '0;
            vj_q      <= '0;
            vk_q      <= '0;
            qj_q      <= '0;
            qk_q      <= '0;
            a_q       <= '0;
            pc_q      <= '0;
            fwd_vld_q <= 1'b0;
            fwd_rd_q  <= '0;
            fwd_tag_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            rs_en_q   <= rs_en_d;
            lsq_en_q  <= lsq_en_d;
            rob_en_q  <= rob_en_d;
            reg_en_q  <= reg_en_d;
            rd_q      <= rd_d;
            dest_q    <= dest_d;
            type_q    <= type_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            a_q       <= a_d;
            pc_q      <= pc_d;
            fwd_vld_q <= fwd_vld_d;
            fwd_rd_q  <= fwd_rd_d;
            fwd_tag_q <= fwd_tag_d;
        end
    end

    assign rs_en_out         = rs_en_q;
    assign lsq_en_out        = lsq_en_q;
    assign rob_en_out        = rob_en_q;
    assign reg_en_out        = reg_en_q;
    assign reg_rd_out        = rd_q;
    assign rob_reg_pos_out   = rd_q;
    assign reg_rd_robnum_out = dest_q;
    assign dest_out          = dest_q;
    assign rob_type_out      = type_q;
    assign type_out          = type_q;
    assign vj_out            = vj_q;
    assign vk_out            = vk_q;
    assign qj_out            = qj_q;
    assign qk_out            = qk_q;
    assign A_out             = a_q;
    assign pc_out            = pc_q;

endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: directed-step bench for dispatch_buffer with hand-computed expectations
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        dec_valid_in, dec_ready_out;
    logic [5:0]  dec_type_in;
    logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
    logic [31:0] dec_imm_in, dec_pc_in;
    logic [4:0]  reg_rs1_out, reg_rs2_out;
    logic [31:0] reg_rs1_data_in, reg_rs2_data_in;
    logic        reg_rs1_busy_in, reg_rs2_busy_in;
    logic [3:0]  reg_rs1_robnum_in, reg_rs2_robnum_in;
    logic [3:0]  rob_rs1_out, rob_rs2_out;
    logic        rob_rs1_rdy_in, rob_rs2_rdy_in;
    logic [31:0] rob_rs1_data_in, rob_rs2_data_in;
    logic [3:0]  rob_idle_pos_in;
    logic        rob_full_in, rs_full_in, lsq_full_in;
    logic [1:0]  cdb_valid_in;
    logic [7:0]  cdb_tag_in;
    logic [63:0] cdb_data_in;
    logic        rs_en_out, lsq_en_out, rob_en_out, reg_en_out;
    logic [4:0]  reg_rd_out, rob_reg_pos_out;
    logic [3:0]  reg_rd_robnum_out, dest_out, qj_out, qk_out;
    logic [5:0]  rob_type_out, type_out;
    logic [31:0] vj_out, vk_out, A_out, pc_out;

    logic [31:0] rf_data [32];
    logic        rf_busy [32];
    logic [3:0]  rf_tag  [32];
    logic        rob_rdy [16];
    logic [31:0] rob_data[16];

    int total  = 0;
    int passed = 0;

    always #5 clk_in = ~clk_in;

    assign reg_rs1_data_in   = rf_data[reg_rs1_out];
    assign reg_rs2_data_in   = rf_data[reg_rs2_out];
    assign reg_rs1_busy_in   = rf_busy[reg_rs1_out];
    assign reg_rs2_busy_in   = rf_busy[reg_rs2_out];
    assign reg_rs1_robnum_in = rf_tag[reg_rs1_out];
    assign reg_rs2_robnum_in = rf_tag[reg_rs2_out];
    assign rob_rs1_rdy_in    = rob_rdy[rob_rs1_out];
    assign rob_rs2_rdy_in    = rob_rdy[rob_rs2_out];
    assign rob_rs1_data_in   = rob_data[rob_rs1_out];
    assign rob_rs2_data_in   = rob_data[rob_rs2_out];

    dispatch_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
        .dec_type_in(dec_type_in), .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
        .dec_rd_in(dec_rd_in), .dec_imm_in(dec_imm_in), .dec_pc_in(dec_pc_in),
        .reg_rs1_out(reg_rs1_out), .reg_rs2_out(reg_rs2_out),
        .reg_rs1_data_in(reg_rs1_data_in), .reg_rs1_busy_in(reg_rs1_busy_in),
        .reg_rs1_robnum_in(reg_rs1_robnum_in),
        .reg_rs2_data_in(reg_rs2_data_in), .reg_rs2_busy_in(reg_rs2_busy_in),
        .reg_rs2_robnum_in(reg_rs2_robnum_in),
        .rob_rs1_out(rob_rs1_out), .rob_rs2_out(rob_rs2_out),
        .rob_rs1_rdy_in(rob_rs1_rdy_in), .rob_rs1_data_in(rob_rs1_data_in),
        .rob_rs2_rdy_in(rob_rs2_rdy_in), .rob_rs2_data_in(rob_rs2_data_in),
        .rob_idle_pos_in(rob_idle_pos_in), .rob_full_in(rob_full_in),
        .rs_full_in(rs_full_in), .lsq_full_in(lsq_full_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .rs_en_out(rs_en_out), .lsq_en_out(lsq_en_out), .rob_en_out(rob_en_out),
        .reg_en_out(reg_en_out), .reg_rd_out(reg_rd_out),
        .reg_rd_robnum_out(reg_rd_robnum_out), .dest_out(dest_out),
        .rob_type_out(rob_type_out), .type_out(type_out), .rob_reg_pos_out(rob_reg_pos_out),
        .vj_out(vj_out), .vk_out(vk_out), .A_out(A_out), .pc_out(pc_out),
        .qj_out(qj_out), .qk_out(qk_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic dec(input logic v, input int t, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
        dec_valid_in = v;
        dec_type_in  = 6'(t);
        dec_rd_in    = 5'(rd);
        dec_rs1_in   = 5'(rs1);
        dec_rs2_in   = 5'(rs2);
        dec_imm_in   = imm;
        dec_pc_in    = pc;
    endtask

    task automatic chk_en(input string tag, input logic rs, input logic lsq, input logic rob, input logic rg);
        chk({tag, ".rs_en"}, 64'(rs_en_out), 64'(rs));
        chk({tag, ".lsq_en"}, 64'(lsq_en_out), 64'(lsq));
        chk({tag, ".rob_en"}, 64'(rob_en_out), 64'(rob));
        chk({tag, ".reg_en"}, 64'(reg_en_out), 64'(rg));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_data[i] = 32'(i * 100);
            rf_busy[i] = 1'b0;
            rf_tag[i]  = '0;
        end
        for (int i = 0; i < 16; i++) begin
            rob_rdy[i]  = 1'b0;
            rob_data[i] = '0;
        end
        rf_data[1] = 32'd5;
        rf_data[2] = 32'd7;
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        rob_full_in = 1'b0; rs_full_in = 1'b0; lsq_full_in = 1'b0;
        cdb_valid_in = '0; cdb_tag_in = '0; cdb_data_in = '0;
        rob_idle_pos_in = 4'd2;
        dec(1'b0, 0, 0, 0, 0, 0, 0);

        // reset state
        tick();
        chk_en("reset", 0, 0, 0, 0);
        chk("reset.dec_ready", 64'(dec_ready_out), 64'd1);
        chk("reset.vj", 64'(vj_out), 64'd0);
        chk("reset.dest", 64'(dest_out), 64'd0);
        rst_in = 1'b1;

        // ADD x3,x1,x2 then SUB x4,x3,x1 back-to-back
        dec(1'b1, TYPE_ADD, 3, 1, 2, 32'h0, 32'h40);
        tick();
        dec(1'b1, TYPE_SUB, 4, 3, 1, 32'h0, 32'h44);
        chk_en("add.wait", 0, 0, 0, 0);
        tick();
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        rob_idle_pos_in = 4'd3;
        chk_en("add", 1, 0, 1, 1);
        chk("add.vj", 64'(vj_out), 64'd5);
        chk("add.vk", 64'(vk_out), 64'd7);
        chk("add.qj", 64'(qj_out), 64'd0);
        chk("add.qk", 64'(qk_out), 64'd0);
        chk("add.dest", 64'(dest_out), 64'd2);
        chk("add.rd", 64'(reg_rd_out), 64'd3);
        chk("add.type", 64'(type_out), 64'(TYPE_ADD));
        chk("add.pc", 64'(pc_out), 64'h40);
        tick();
        chk_en("sub", 1, 0, 1, 1);
        chk("sub.qj_fwd", 64'(qj_out), 64'd2);
        chk("sub.vj_fwd", 64'(vj_out), 64'd0);
        chk("sub.vk", 64'(vk_out), 64'd5);
        chk("sub.qk", 64'(qk_out), 64'd0);
        chk("sub.dest", 64'(reg_rd_robnum_out), 64'd3);
        chk("sub.type", 64'(rob_type_out), 64'(TYPE_SUB));
        tick();
        chk_en("idle", 0, 0, 0, 0);

        // LW stalled on a full LSQ while the decoder keeps streaming
        lsq_full_in = 1'b1;
        dec(1'b1, TYPE_LW, 5, 1, 0, 32'd16, 32'h100);
        tick();
        dec(1'b1, TYPE_ADD, 6, 1, 2, 32'h0, 32'h104);
        chk("lw.ready1", 64'(dec_ready_out), 64'd1);
        tick();
        chk("lw.ready2", 64'(dec_ready_out), 64'd1);
        chk("lw.stall2", 64'(lsq_en_out), 64'd0);
        tick();
        chk("lw.ready3", 64'(dec_ready_out), 64'd1);
        chk("lw.stall3", 64'(lsq_en_out), 64'd0);
        tick();
        chk("lw.full", 64'(dec_ready_out), 64'd0);
        chk_en("lw.stall4", 0, 0, 0, 0);
        lsq_full_in = 1'b0;
        rob_idle_pos_in = 4'd4;
        tick();
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        chk_en("lw", 0, 1, 1, 1);
        chk("lw.vj", 64'(vj_out), 64'd5);
        chk("lw.vk", 64'(vk_out), 64'd0);
        chk("lw.qk", 64'(qk_out), 64'd0);
        chk("lw.A", 64'(A_out), 64'd16);
        chk("lw.pc", 64'(pc_out), 64'h100);
        chk("lw.dest", 64'(dest_out), 64'd4);
        chk("lw.regpos", 64'(rob_reg_pos_out), 64'd5);
        chk("lw.ready_after", 64'(dec_ready_out), 64'd1);
        tick();
        chk_en("drain1", 1, 0, 1, 1);
        chk("drain1.vj", 64'(vj_out), 64'd5);
        tick();
        chk("drain2.rs_en", 64'(rs_en_out), 64'd1);
        tick();
        chk("drain3.rs_en", 64'(rs_en_out), 64'd1);
        tick();
        chk_en("drained", 0, 0, 0, 0);

        // CDB channel 1 resolves rs1, ROB ready resolves rs2; then an unresolved source
        rf_busy[8] = 1'b1; rf_tag[8] = 4'd5;
        rf_busy[9] = 1'b1; rf_tag[9] = 4'd6;
        rob_rdy[6] = 1'b1; rob_data[6] = 32'h99;
        rf_busy[11] = 1'b1; rf_tag[11] = 4'd7;
        cdb_valid_in = 2'b10;
        cdb_tag_in   = {4'd5, 4'd3};
        cdb_data_in  = {32'hAB, 32'h11};
        dec(1'b1, TYPE_ADD, 7, 8, 9, 32'h0, 32'h200);
        tick();
        dec(1'b1, TYPE_SUB, 10, 11, 0, 32'h0, 32'h204);
        tick();
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        cdb_valid_in = 2'b00;
        chk("cdb.vj", 64'(vj_out), 64'hAB);
        chk("cdb.qj", 64'(qj_out), 64'd0);
        chk("rob.vk", 64'(vk_out), 64'h99);
        chk("rob.qk", 64'(qk_out), 64'd0);
        tick();
        chk("wait.vj", 64'(vj_out), 64'd0);
        chk("wait.qj", 64'(qj_out), 64'd7);
        chk("wait.qk", 64'(qk_out), 64'd0);

        // flush a full buffer while the decoder is presenting
        rs_full_in = 1'b1;
        dec(1'b1, TYPE_ADD, 12, 1, 2, 32'h0, 32'h300);
        tick();
        tick();
        tick();
        tick();
        chk("flush.pre_ready", 64'(dec_ready_out), 64'd0);
        chk("flush.pre_rs_en", 64'(rs_en_out), 64'd0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        rs_full_in = 1'b0;
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        chk("flush.ready", 64'(dec_ready_out), 64'd1);
        chk_en("flush", 0, 0, 0, 0);
        tick();
        chk_en("flush.empty", 0, 0, 0, 0);

        // rdy_in low holds the issue pulse
        rob_idle_pos_in = 4'd9;
        dec(1'b1, TYPE_ADD, 3, 1, 2, 32'h0, 32'h400);
        tick();
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("hold.issue", 64'(rs_en_out), 64'd1);
        chk("hold.dest", 64'(dest_out), 64'd9);
        rdy_in = 1'b0;
        rob_idle_pos_in = 4'd10;
        tick();
        chk("hold.rs_en", 64'(rs_en_out), 64'd1);
        chk("hold.rob_en", 64'(rob_en_out), 64'd1);
        chk("hold.dest2", 64'(dest_out), 64'd9);
        rdy_in = 1'b1;
        tick();
        chk_en("hold.release", 0, 0, 0, 0);

        // asynchronous reset with entries queued
        rs_full_in = 1'b1;
        dec(1'b1, TYPE_ADD, 13, 1, 2, 32'h0, 32'h500);
        tick();
        tick();
        tick();
        dec(1'b0, 0, 0, 0, 0, 0, 0);
        rs_full_in = 1'b0;
        tick();
        chk("arst.pre", 64'(rs_en_out), 64'd1);
        chk("arst.pre_vj", 64'(vj_out), 64'd5);
        #2;
        rst_in = 1'b0;
        #1;
        chk_en("arst", 0, 0, 0, 0);
        chk("arst.ready", 64'(dec_ready_out), 64'd1);
        chk("arst.vj", 64'(vj_out), 64'd0);
        chk("arst.dest", 64'(dest_out), 64'd0);
        tick();
        rst_in = 1'b1;
        tick();
        chk_en("arst.empty", 0, 0, 0, 0);
        chk("arst.ready2", 64'(dec_ready_out), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
# dispatch_buffer

Parametrised dispatch stage between the decoder and the out-of-order back end (ROB, reservation station, load/store queue, register rename table). Buffers up to DEPTH decoded instructions and resolves source operands for the head entry from the register file, the ROB and NCDB common-data-bus channels. Issues at most one instruction per cycle through registered outputs, with back-pressure from every consumer and a full flush on mispredict. Adds a decode FIFO, structural stalls, CDB snooping and back-to-back rename forwarding.

## Interface
Parameters:
- DEPTH, 4: buffer entries, power of two, ≥2
- XLEN, 32: data/imm/pc width
- ROB_W, 4: ROB tag width; tag 0 is reserved as `NULL` (no dependency) and never allocated
- REG_W, 5: architectural register index width
- TYPE_W, 6: instruction-type code width
- NCDB, 2: number of CDB broadcast channels

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global run enable; low freezes all state
- flush_in  in  1  mispredict flush
- dec_valid_in / dec_ready_out  in/out  1  decoder handshake
- dec_type_in  in  TYPE_W; dec_rs1_in, dec_rs2_in, dec_rd_in  in  REG_W; dec_imm_in, dec_pc_in  in  XLEN
- reg_rs1_out, reg_rs2_out  out  REG_W  head sources, combinational lookup
- reg_rsN_data_in  in  XLEN; reg_rsN_busy_in  in  1; reg_rsN_robnum_in  in  ROB_W  (N=1,2)
- rob_rs1_out, rob_rs2_out  out  ROB_W  ROB lookup tags, combinational
- rob_rsN_rdy_in  in  1; rob_rsN_data_in  in  XLEN
- rob_idle_pos_in  in  ROB_W; rob_full_in, rs_full_in, lsq_full_in  in  1
- cdb_valid_in  in  NCDB; cdb_tag_in  in  NCDB*ROB_W; cdb_data_in  in  NCDB*XLEN
- rs_en_out, lsq_en_out, rob_en_out, reg_en_out  out  1  one-cycle issue pulses
- reg_rd_out  out  REG_W; reg_rd_robnum_out, dest_out  out  ROB_W
- rob_type_out, type_out  out  TYPE_W; rob_reg_pos_out  out  REG_W
- vj_out, vk_out, A_out, pc_out  out  XLEN; qj_out, qk_out  out  ROB_W

## Operation
- FIFO: head/tail pointers, log2(DEPTH)+1-bit count. dec_ready_out = count < DEPTH. Enqueue when dec_valid_in && dec_ready_out. No pass-through when full.
- Memory ops are types `LB`..`SW`. They target the LSQ. All other types target the RS.
- Issue condition: count>0 && !rob_full_in && (mem ? !lsq_full_in : !rs_full_in) && !flush_in && rdy_in. On issue, the head pops and all outputs load on the same edge.
- Operand resolution, per source, highest priority first:
  1. Source is x0: v=0, q=NULL.
  2. Previous cycle issued and renamed this register (rd≠0): q = that tag, v=0. This covers a rename-table update not yet visible.
  3. reg busy=0: v = reg data, q=NULL.
  4. ROB ready: v = ROB data, q=NULL.
  5. Any CDB channel valid with tag = robnum: v = cdb data (lowest channel index wins), q=NULL.
  6. Otherwise: v=0, q = robnum.
- Issue fields: rob_en_out=1 and the target en=1. reg_en_out=1 only if rd≠0. dest_out = reg_rd_robnum_out = rob_idle_pos_in. A_out = imm. pc_out = pc. rob_reg_pos_out = reg_rd_out = rd.
- Flush: count and pointers clear, and the enqueue that cycle is dropped. Next cycle all en outputs are 0 and the forwarding record clears.
- rdy_in low: every register holds, including en outputs.

## Timing
- Reset: all en outputs 0; data/tag outputs 0; count 0; dec_ready_out 1.
- Latency: enqueue at edge t into an empty buffer gives en pulses in the cycle after edge t+1 (2 cycles). Sustained throughput is 1/cycle.
- Every en output is high for exactly one cycle per issue unless rdy_in holds it.
- Enqueue and issue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Flush has priority over enqueue and issue in the same cycle.

## Structure
- `define.vh` holds: type codes including `LB`/`SW` bounds, `NULL`, `ENABLE`/`DISABLE`, widths.
- Sub-module `dispatch_operand_resolve`: combinational, instantiated twice (rs1, rs2). Inputs are the lookup results, the CDB bus and the forwarding record. Outputs are v and q.
- The FIFO and the output registers stay inline.

## Test plan
- Reset mid-stream with 3 entries queued -> all en 0 and dec_ready_out 1 immediately, asynchronously.
- Enqueue ADD x3,x1,x2 with x1/x2 not busy (data 5,7) and rob_idle_pos=2 -> 2 cycles later rs_en=rob_en=reg_en=1, vj=5, vk=7, qj=qk=0, dest=2.
- ADD x3 (tag 2) followed by SUB x4,x3,x1 -> SUB issues next cycle with qj=2 despite reg busy_in=0 (rename forwarding).
- Head LW with lsq_full_in=1 for 3 cycles, DEPTH=4, decoder streaming -> no lsq_en; dec_ready_out drops at count 4; LW issues one cycle after lsq_full_in falls.
- Head rs1 busy with robnum 5, ROB not ready, cdb_valid[1] with tag 5 and data 0xAB -> vj=0xAB, qj=0.
- flush_in while full and dec_valid_in=1 -> next cycle count 0, no en pulses, dec_ready_out=1.
